// File: rtl/toggle_debouncer.sv
// Push-button debouncer: two-flop synchronizer feeding a four-state qualification FSM.
// Emits a one-cycle t pulse on every accepted press and tracks the debounced level.
module toggle_debouncer #(
  parameter int STABLE_CNT = 50000,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       t,
  output logic       level,
  output logic       busy,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    QUAL_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    QUAL_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

  logic             sync1;
  logic             sync2;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             t_n;
  logic             level_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      t     <= 1'b0;
      level <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      t     <= t_n;
      level <= level_n;
    end
  end

  // Any opposite sample while qualifying drops back to the idle state; the count restarts from zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    t_n     = 1'b0;
    level_n = level;
    case (state)
      IDLE_LOW: begin
        if (sync2) begin
          state_n = QUAL_HIGH;
          cnt_n   = '0;
        end
      end
      QUAL_HIGH: begin
        if (!sync2) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
          level_n = 1'b1;
          t_n     = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync2) begin
          state_n = QUAL_LOW;
          cnt_n   = '0;
        end
      end
      QUAL_LOW: begin
        if (sync2) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
          level_n = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE_LOW;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy      = (state == QUAL_HIGH) || (state == QUAL_LOW);
  assign fsm_state = state;

endmodule

// File: tb/tb_toggle_debouncer.sv
// Bench for toggle_debouncer with STABLE_CNT=4 (plus a STABLE_CNT=1 instance on the same btn).
// Expected outputs per edge are derived from the latency rules and queued as stimulus is driven.
module tb_toggle_debouncer;

  localparam int S = 4;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       t;
  logic       level;
  logic       busy;
  logic [1:0] fsm_state;
  logic       t1;
  logic       level1;
  logic       busy1;
  logic [1:0] fsm_state1;
  logic       q;
  logic       qbar;

  int n_vec = 0;
  int n_err = 0;
  logic [6:0] exp_q[$];

  toggle_debouncer #(.STABLE_CNT(S), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .btn(btn),
    .t(t), .level(level), .busy(busy), .fsm_state(fsm_state)
  );

  toggle_debouncer #(.STABLE_CNT(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .btn(btn),
    .t(t1), .level(level1), .busy(busy1), .fsm_state(fsm_state1)
  );

  // Downstream toggle flip-flop driven by t.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else if (t) q <= ~q;
  end
  assign qbar = ~q;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: drive btn at negedge, queue the expectation, compare just after the posedge.
  task automatic step(input logic b, input logic [2:0] e, input logic c1, input logic [2:0] e1);
    logic [6:0] got;
    @(negedge clk);
    btn = b;
    exp_q.push_back({c1, e1, e});
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("t_level_busy", {5'd0, t, level, busy}, {5'd0, got[2:0]});
    if (got[6]) chk("cnt1_t_level_busy", {5'd0, t1, level1, busy1}, {5'd0, got[5:3]});
  endtask

  task automatic press_seq(input int n, input logic c1);
    for (int i = 0; i < n; i++)
      step(1'b1, {i == S + 2, i >= S + 2, (i >= 2) && (i <= S + 1)},
           c1, {i == 3, i >= 3, i == 2});
  endtask

  task automatic release_seq(input int n, input logic c1);
    for (int i = 0; i < n; i++)
      step(1'b0, {1'b0, i < S + 2, (i >= 2) && (i <= S + 1)},
           c1, {1'b0, i < 3, i == 2});
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, {1'b0, b, 1'b0}, 1'b0, 3'd0);
  endtask

  initial begin
    logic qe;
    rst = 1'b0;
    btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {5'd0, t, level, busy}, 8'd0);
    chk("reset_state", {6'd0, fsm_state}, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    // clean press, steady high, clean release
    press_seq(10, 1'b1);
    hold(1'b1, $urandom_range(1, 6));
    release_seq(10, 1'b1);
    hold(1'b0, $urandom_range(1, 6));

    // single-cycle glitch from IDLE_LOW
    step(1'b1, 3'b000, 1'b1, 3'b000);
    for (int i = 1; i < 8; i++) step(1'b0, {2'b00, i == 2}, 1'b1, {2'b00, i == 2});
    chk("glitch_state", {6'd0, fsm_state}, 8'd0);

    // bounce: high 2, low 1, then high held; only the final rise is accepted
    for (int i = 0; i < 12; i++) begin
      logic b;
      b = (i != 2);
      step(b, {i == 9, i >= 9, (i == 2) || (i == 3) || ((i >= 5) && (i <= 8))}, 1'b0, 3'd0);
    end
    release_seq(10, 1'b0);
    hold(1'b0, $urandom_range(1, 6));

    // reset mid-qualification with cnt at 2
    for (int i = 0; i < 5; i++) step(1'b1, {2'b00, i >= 2}, 1'b0, 3'd0);
    rst = 1'b0;
    #1;
    chk("abort_outputs", {5'd0, t, level, busy}, 8'd0);
    chk("abort_state", {6'd0, fsm_state}, 8'd0);
    rst = 1'b1;
    press_seq(10, 1'b0);
    release_seq(10, 1'b0);

    // toggle flip-flop chain from a fresh reset
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("chain_reset_q", {7'd0, q}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    qe = 1'b0;
    for (int p = 0; p < 3; p++) begin
      press_seq(10, 1'b0);
      qe = ~qe;
      chk("chain_q", {7'd0, q}, {7'd0, qe});
      chk("chain_qbar", {7'd0, qbar}, {7'd0, ~qe});
      release_seq(10, 1'b0);
      hold(1'b0, $urandom_range(1, 6));
    end
    chk("chain_q_final", {7'd0, q}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/toggle_debouncer.md
TOGGLE_DEBOUNCER -- requirements
Module: toggle_debouncer

Interface
REQ-001 The block SHALL have parameter STABLE_CNT, default 50000, the number of consecutive stable synchronized samples required to accept a level change; legal range 1 to 2^CNT_W-1.
REQ-002 The block SHALL have parameter CNT_W, default 16, the qualification counter width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port btn  input  1  raw, asynchronous, bouncing push-button level.
REQ-006 The block SHALL have port t  output  1  single-cycle toggle pulse on each accepted press (0->1); it drives the t input of the downstream toggle flip-flop.
REQ-007 The block SHALL have port level  output  1  debounced button level.
REQ-008 The block SHALL have port busy  output  1  high while a level change is being qualified.

Function
REQ-009 btn SHALL pass through a two-flop synchronizer (sync1, sync2); the FSM and counter SHALL use only sync2.
REQ-010 The FSM SHALL have states IDLE_LOW, QUAL_HIGH, IDLE_HIGH, QUAL_LOW.
REQ-011 IDLE_LOW: sync2=1 -> QUAL_HIGH with cnt<=0; otherwise hold.
REQ-012 QUAL_HIGH: sync2=0 -> IDLE_LOW, cnt<=0, no pulse (bounce rejected); sync2=1 and cnt==STABLE_CNT-1 -> IDLE_HIGH, level<=1, t<=1; otherwise cnt<=cnt+1.
REQ-013 IDLE_HIGH: sync2=0 -> QUAL_LOW with cnt<=0; otherwise hold.
REQ-014 QUAL_LOW: sync2=1 -> IDLE_HIGH, cnt<=0; sync2=0 and cnt==STABLE_CNT-1 -> IDLE_LOW, level<=0; otherwise cnt<=cnt+1. Release SHALL NOT produce a t pulse.
REQ-015 t SHALL be registered, high for exactly one cycle per accepted press, and never high on two consecutive cycles.
REQ-016 busy SHALL be decoded from the state register: 1 in QUAL_HIGH or QUAL_LOW, 0 otherwise.
REQ-017 cnt SHALL never exceed STABLE_CNT-1 and SHALL never wrap.
REQ-018 Latency: btn rises and stays high before edge k. The FSM enters QUAL_HIGH at edge k+2. t and level assert at edge k+2+STABLE_CNT. t deasserts at edge k+3+STABLE_CNT. Release has the same latency on level.
REQ-019 For STABLE_CNT=1, acceptance SHALL occur at the first edge after entering QUAL_*.
REQ-020 Any opposite sample during QUAL_* SHALL restart qualification from the idle state; partial counts SHALL NOT be retained.

Reset
REQ-021 rst=0 SHALL immediately clear sync1, sync2, cnt, t, level and busy to 0 and force state IDLE_LOW, independent of clk.
REQ-022 Reset asserted mid-qualification SHALL abort it with no t pulse.
REQ-023 After rst deasserts with btn held high, the block SHALL requalify from IDLE_LOW with full REQ-018 latency.

Verification (STABLE_CNT=4)
REQ-024 Clean press: btn 0->1 before edge 0, held -> busy=1 from edge 2 to edge 6; t=1 only between edges 6 and 7; level=1 from edge 6.
REQ-025 Bounce: btn high for 2 cycles, low for 1 cycle, then high and held -> exactly one t pulse, timed per REQ-018 from the final rise; no pulse from the first burst.
REQ-026 Release: from IDLE_HIGH, btn 1->0 before edge 0 -> level=0 at edge 6; t stays 0 throughout.
REQ-027 Reset abort: rst=0 asynchronously while in QUAL_HIGH with cnt=2 -> all outputs 0 immediately; after rst=1 with btn still high, t pulses 6 edges after the first post-reset edge.
REQ-028 Chain: t drives the downstream toggle flip-flop; three clean, separated presses -> q sequence 0->1->0->1, qbar always its complement after reset.
REQ-029 Glitch: single-cycle btn=1 pulse from IDLE_LOW -> state returns to IDLE_LOW; t and level stay 0.
